// File: rtl/lzy_cmp_stat.sv
`default_nettype none
// ============================================================================
// Module      : lzy_cmp_stat
// Description : Lazy statistics collector for a three-output magnitude
//               comparator (QE/QG/QS). One sample is accepted per three-cycle
//               IDLE -> CHECK -> UPDATE pass. The block counts E/G/S results
//               with saturating counters, tracks the last legal class and the
//               run length of identical results, and raises a sticky error
//               flag when a sample is not one-hot.
//
// Ports       : CLK       rising-edge clock
//               RST       synchronous active-high reset (highest priority)
//               IN_VALID  comparator triple valid this cycle
//               QE/QG/QS  comparator equal / greater / smaller outputs
//               CLR       synchronous clear of all statistics, aborts sample
//               IN_READY  block can accept a sample (combinational)
//               DONE      one-cycle pulse, statistics include last sample
//               CNT_E/G/S saturating per-class result counters
//               LAST      last legal class: 00 none, 01 S, 10 G, 11 E
//               RUN_LEN   saturating count of consecutive identical results
//               ERR       sticky illegal-sample flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module lzy_cmp_stat #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    input  logic             QE,
    input  logic             QG,
    input  logic             QS,
    input  logic             CLR,
    output logic             IN_READY,
    output logic             DONE,
    output logic [CNT_W-1:0] CNT_E,
    output logic [CNT_W-1:0] CNT_G,
    output logic [CNT_W-1:0] CNT_S,
    output logic [1:0]       LAST,
    output logic [RUN_W-1:0] RUN_LEN,
    output logic             ERR
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CHECK  = 2'd1;
    localparam logic [1:0] c_UPDATE = 2'd2;

    // Class codes double as the LAST output encoding; 00 marks "illegal"
    // internally and "none" on LAST, which never matches a legal class.
    localparam logic [1:0] c_CLS_NONE = 2'b00;
    localparam logic [1:0] c_CLS_S    = 2'b01;
    localparam logic [1:0] c_CLS_G    = 2'b10;
    localparam logic [1:0] c_CLS_E    = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] c_RUN_MAX = {RUN_W{1'b1}};

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic [2:0]       r_lat;      // {QE,QG,QS} captured at acceptance
    logic [1:0]       r_cls;      // classified sample, c_CLS_NONE = illegal
    logic [1:0]       w_cls;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt_e;
    logic [CNT_W-1:0] r_cnt_g;
    logic [CNT_W-1:0] r_cnt_s;
    logic [1:0]       r_last;
    logic [RUN_W-1:0] r_run;
    logic             r_err;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign IN_READY = (r_state == c_IDLE) && !CLR;
    assign w_accept = IN_VALID && IN_READY;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (w_accept) w_state_nxt = c_CHECK;
            c_CHECK:  w_state_nxt = c_UPDATE;
            c_UPDATE: w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Classification of the latched triple (only exact one-hot is legal)
    // ------------------------------------------------------------------------
    always_comb begin
        w_cls = c_CLS_NONE;
        case (r_lat)
            3'b100:  w_cls = c_CLS_E;
            3'b010:  w_cls = c_CLS_G;
            3'b001:  w_cls = c_CLS_S;
            default: w_cls = c_CLS_NONE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: capture, classify, update statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_lat   <= 3'b000;
            r_cls   <= c_CLS_NONE;
            r_done  <= 1'b0;
            r_cnt_e <= '0;
            r_cnt_g <= '0;
            r_cnt_s <= '0;
            r_last  <= c_CLS_NONE;
            r_run   <= '0;
            r_err   <= 1'b0;
        end else begin
            // DONE follows the UPDATE edge by exactly one cycle.
            r_done <= (r_state == c_UPDATE);

            // Inputs are only sampled on acceptance; toggling while busy
            // has no effect.
            if (w_accept) begin
                r_lat <= {QE, QG, QS};
            end

            if (r_state == c_CHECK) begin
                r_cls <= w_cls;
            end

            if (r_state == c_UPDATE) begin
                if (r_cls == c_CLS_NONE) begin
                    r_err <= 1'b1;
                    r_run <= '0;
                end else begin
                    case (r_cls)
                        c_CLS_E: if (r_cnt_e != c_CNT_MAX) r_cnt_e <= r_cnt_e + CNT_W'(1);
                        c_CLS_G: if (r_cnt_g != c_CNT_MAX) r_cnt_g <= r_cnt_g + CNT_W'(1);
                        default: if (r_cnt_s != c_CNT_MAX) r_cnt_s <= r_cnt_s + CNT_W'(1);
                    endcase
                    if (r_cls == r_last) begin
                        if (r_run != c_RUN_MAX) r_run <= r_run + RUN_W'(1);
                    end else begin
                        r_run <= RUN_W'(1);
                    end
                    r_last <= r_cls;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    assign DONE    = r_done;
    assign CNT_E   = r_cnt_e;
    assign CNT_G   = r_cnt_g;
    assign CNT_S   = r_cnt_s;
    assign LAST    = r_last;
    assign RUN_LEN = r_run;
    assign ERR     = r_err;

endmodule
`default_nettype wire

// File: doc/lzy_cmp_stat.md
LZY_CMP_STAT -- requirements
Module: lzy_cmp_stat

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, which sets the width of each result counter.
REQ-002 The module SHALL have parameter RUN_W, default 4, which sets the width of the run-length counter.
REQ-003 The module SHALL run on one clock and use a synchronous, active-high reset.
REQ-004 Port CLK  input  1  rising-edge clock for all state.
REQ-005 Port RST  input  1  synchronous active-high reset.
REQ-006 Port IN_VALID  input  1  comparator result on QE/QG/QS is valid this cycle.
REQ-007 Port QE  input  1  comparator "A equals B" output.
REQ-008 Port QG  input  1  comparator "A greater than B" output.
REQ-009 Port QS  input  1  comparator "A smaller than B" output.
REQ-010 Port CLR  input  1  synchronous clear of the statistics.
REQ-011 Port IN_READY  output  1  block can accept a sample.
REQ-012 Port DONE  output  1  one-cycle pulse: the statistics now include the last sample.
REQ-013 Ports CNT_E, CNT_G, CNT_S  output  CNT_W each  saturating counts of E, G and S results.
REQ-014 Port LAST  output  2  last valid class: 00 none, 01 S, 10 G, 11 E.
REQ-015 Port RUN_LEN  output  RUN_W  number of consecutive identical valid results, saturating.
REQ-016 Port ERR  output  1  sticky flag: an illegal (not one-hot) sample was seen.

Function
REQ-017 FSM states SHALL be IDLE, CHECK and UPDATE, and the reset state SHALL be IDLE.
REQ-018 IN_READY SHALL equal (state==IDLE) AND NOT CLR.
REQ-019 A sample SHALL be accepted when IN_VALID AND IN_READY; QE/QG/QS are latched at that edge and the FSM moves IDLE->CHECK.
REQ-020 In CHECK the latched triple SHALL be classified and registered (E=100, G=010, S=001, anything else illegal), then CHECK->UPDATE unconditionally.
REQ-021 In UPDATE the statistics SHALL be updated at the clock edge, then UPDATE->IDLE unconditionally, and DONE SHALL be high for exactly the following cycle.
REQ-022 Latency SHALL be fixed: accept at edge t0, statistics visible after edge t2, DONE high between t2 and t3, IN_READY high again after t2 so back-to-back acceptance is possible every 3 cycles.
REQ-023 For a legal class, the matching counter SHALL increment by 1 and hold at 2^CNT_W-1, which is never wrapped.
REQ-024 For a legal class, RUN_LEN SHALL become RUN_LEN+1 (saturating at 2^RUN_W-1) if the class equals LAST, else 1; LAST is then set to the class.
REQ-025 For an illegal sample, ERR SHALL be set, no counter changes, LAST holds, and RUN_LEN is cleared to 0; DONE still pulses.
REQ-026 ERR SHALL stay set until RST or CLR.
REQ-027 IN_VALID while not IDLE SHALL be ignored, with no queueing, and QE/QG/QS SHALL not be sampled.
REQ-028 CLR SHALL act in any state: it zeroes all counters, LAST, RUN_LEN and ERR, aborts any in-flight sample, forces IDLE, and DONE is not pulsed.
REQ-029 When CLR and IN_VALID are high together in IDLE, CLR SHALL win and the sample is not accepted.
REQ-030 All outputs SHALL be registered except IN_READY.

Reset
REQ-031 RST SHALL take priority over CLR and IN_VALID.
REQ-032 On RST: state=IDLE, CNT_E=CNT_G=CNT_S=0, LAST=00, RUN_LEN=0, ERR=0, DONE=0, and IN_READY=1 in the first cycle after release (CLR low).
REQ-033 RST asserted in CHECK or UPDATE SHALL discard the sample without a DONE pulse.

Verification
REQ-034 Scenario: after reset, three samples G (010), G (010), E (100) -> CNT_G=2, CNT_E=1, CNT_S=0, LAST=11, RUN_LEN=1, DONE pulsed 3 times, each 2 edges after acceptance.
REQ-035 Scenario: 20 consecutive S samples with RUN_W=4 -> CNT_S=20, RUN_LEN=15 (saturated), LAST=01.
REQ-036 Scenario: sample 110 after two E samples -> ERR=1, CNT_E=2, LAST=11, RUN_LEN=0; a following E sample gives RUN_LEN=1 and ERR stays 1.
REQ-037 Scenario: 260 G samples with CNT_W=8 -> CNT_G=255 with no wrap.
REQ-038 Scenario: IN_VALID held high continuously -> acceptances exactly every 3 cycles; toggling QE/QG/QS during CHECK/UPDATE has no effect.
REQ-039 Scenario: CLR during CHECK with counters nonzero -> all statistics 0, ERR=0, no DONE, IDLE on the next cycle; CLR together with IN_VALID in IDLE -> no acceptance.
